// File: rtl/tictactoe_pkg.sv
// Shared types and the win-line table for the tic-tac-toe board judge.
// Optional feature macro used by board_judge: JUDGE_WINMASK_EN.
package tictactoe_pkg;

  localparam int CELL_W    = 2;
  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P0    = 2'b01,
    P1    = 2'b10,
    BAD   = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } judge_state_t;

  // Cell indices 0..8 map to a..i (row-major).
  localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},   // 0 abc
    '{4'd3, 4'd4, 4'd5},   // 1 def
    '{4'd6, 4'd7, 4'd8},   // 2 ghi
    '{4'd0, 4'd3, 4'd6},   // 3 adg
    '{4'd1, 4'd4, 4'd7},   // 4 beh
    '{4'd2, 4'd5, 4'd8},   // 5 cfi
    '{4'd0, 4'd4, 4'd8},   // 6 aei
    '{4'd2, 4'd4, 4'd6}    // 7 ceg
  };

  // Nine-bit mask of a line's cells, bit8 = a .. bit0 = i.
  function automatic logic [8:0] line_mask(input logic [2:0] idx);
    logic [8:0] m;
    m = '0;
    for (int j = 0; j < 3; j++) begin
      m[8 - int'(LINE_CELLS[idx][j])] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/board_judge_line_check.sv
// Combinational check of one win line: three equal owned cells.
module line_check
  import tictactoe_pkg::*;
(
  input  cell_t c0,
  input  cell_t c1,
  input  cell_t c2,
  output logic  match,
  output cell_t owner
);

  // Empty and invalid cells never form a line, even when all three agree.
  always_comb begin
    match = (c0 == c1) && (c1 == c2) && ((c0 == P0) || (c0 == P1));
    owner = match ? c0 : EMPTY;
  end

endmodule

// File: rtl/board_judge.sv
// Board judge: snapshots the 3x3 grid on start and scans the eight win lines,
// one per clock, reporting winner / win_line / draw with a done pulse.
// Optional: JUDGE_WINMASK_EN adds win_mask (bit8 = a .. bit0 = i).
// Handshake: start is a level sampled only in IDLE with game_over low and
// clear low; done pulses for one cycle and results hold until start/clear.
module board_judge
  import tictactoe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] d,
  input  logic [1:0] e,
  input  logic [1:0] f,
  input  logic [1:0] g,
  input  logic [1:0] h,
  input  logic [1:0] i,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [2:0] win_line,
  output logic       draw,
  output logic       game_over
`ifdef JUDGE_WINMASK_EN
  ,
  output logic [8:0] win_mask
`endif
);

  judge_state_t state_q, state_d;
  cell_t        snap_q [NUM_CELLS];
  cell_t        snap_d [NUM_CELLS];
  cell_t        cells  [NUM_CELLS];
  logic [2:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  cell_t        winner_q, winner_d;
  logic [2:0]   line_q, line_d;
  logic         draw_q, draw_d;
  logic         go_q, go_d;
  logic         match;
  cell_t        owner;
  logic         all_occupied;
`ifdef JUDGE_WINMASK_EN
  logic [8:0]   mask_q, mask_d;
`endif

  // Live grid as a cell array, index 0 = a.
  always_comb begin
    cells[0] = cell_t'(a);
    cells[1] = cell_t'(b);
    cells[2] = cell_t'(c);
    cells[3] = cell_t'(d);
    cells[4] = cell_t'(e);
    cells[5] = cell_t'(f);
    cells[6] = cell_t'(g);
    cells[7] = cell_t'(h);
    cells[8] = cell_t'(i);
  end

  // Invalid (11) cells count as occupied for the draw decision.
  always_comb begin
    all_occupied = 1'b1;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (snap_q[k] == EMPTY) all_occupied = 1'b0;
    end
  end

  // Single checker, fed the snapshot cells of the line under scan.
  line_check u_line_check (
    .c0    (snap_q[LINE_CELLS[idx_q][0]]),
    .c1    (snap_q[LINE_CELLS[idx_q][1]]),
    .c2    (snap_q[LINE_CELLS[idx_q][2]]),
    .match (match),
    .owner (owner)
  );

  // Next-state logic: clear dominates every state and any start.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    winner_d = winner_q;
    line_d   = line_q;
    draw_d   = draw_q;
    go_d     = go_q;
`ifdef JUDGE_WINMASK_EN
    mask_d   = mask_q;
`endif
    if (clear) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      winner_d = EMPTY;
      line_d   = '0;
      draw_d   = 1'b0;
      go_d     = 1'b0;
`ifdef JUDGE_WINMASK_EN
      mask_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !go_q) begin
            snap_d   = cells;
            idx_d    = '0;
            winner_d = EMPTY;
            line_d   = '0;
            draw_d   = 1'b0;
            busy_d   = 1'b1;
            state_d  = SCAN;
`ifdef JUDGE_WINMASK_EN
            mask_d   = '0;
`endif
          end
        end
        SCAN: begin
          if (match) begin
            winner_d = owner;
            line_d   = idx_q;
            state_d  = DONE;
`ifdef JUDGE_WINMASK_EN
            mask_d   = line_mask(idx_q);
`endif
          end else if (idx_q == 3'(NUM_LINES - 1)) begin
            draw_d  = all_occupied;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        DONE: begin
          done_d  = 1'b1;
          go_d    = go_q | (winner_q != EMPTY) | draw_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      for (int k = 0; k < NUM_CELLS; k++) snap_q[k] <= EMPTY;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      winner_q <= EMPTY;
      line_q   <= '0;
      draw_q   <= 1'b0;
      go_q     <= 1'b0;
`ifdef JUDGE_WINMASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      winner_q <= winner_d;
      line_q   <= line_d;
      draw_q   <= draw_d;
      go_q     <= go_d;
`ifdef JUDGE_WINMASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign winner    = winner_q;
  assign win_line  = line_q;
  assign draw      = draw_q;
  assign game_over = go_q;
`ifdef JUDGE_WINMASK_EN
  assign win_mask  = mask_q;
`endif

endmodule
